mips_normalizer: RTL

Multi-cycle leading-zero/leading-one counter and normalizer for the MIPS CPU execution stage. It serves CLZ/CLO and feeds normalized operands to downstream shift and arithmetic logic. It is the inverse of the barrel shift path: the barrel shifter takes data and a count and produces shifted data; this block takes data and produces the count plus the data normalized by that count. It resolves one binary-search stage per cycle (16, 8, 4, 2, 1) under a start/busy/done handshake.

---
 rtl/mips_normalizer_if.sv | 25 ++
 rtl/mips_normalizer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mips_normalizer_if.sv
// Handshake and result bundle for the multi-cycle leading-run counter / normalizer.
// The requester uses the master modport; the normalizer uses the slave modport.
interface mips_normalizer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
);
    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] norm_out;
    logic             full_run;

    modport master (
        output start, mode, data_in,
        input  busy, done, count, norm_out, full_run
    );

    modport slave (
        input  start, mode, data_in,
        output busy, done, count, norm_out, full_run
    );
endinterface

// File: rtl/mips_normalizer.sv
// CLZ/CLO normalizer: five-stage binary search (16,8,4,2,1), one stage per cycle.
// Optional macro NORM_CTZ_EN adds mode=10 count-trailing-zeros with right-shift normalization.
module mips_normalizer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    mips_normalizer_if.slave bus
);
    localparam int unsigned STG_W    = 3;
    localparam int unsigned SH_W     = 5;
    localparam int unsigned LAST_STG = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] det_q, det_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] norm_q, norm_d;
    logic             full_q, full_d;
`ifdef NORM_CTZ_EN
    logic             rev_q, rev_d;
    logic [WIDTH-1:0] data_rev;
`endif

    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] mask;
    logic             take;
    logic [WIDTH-1:0] det_step;
    logic [WIDTH-1:0] sh_step;
    logic [CNT_W-1:0] acc_step;
    logic [WIDTH-1:0] det_load;

    // One binary-search stage: skip s leading zeros of det when they are all clear
    always_comb begin
        shamt    = SH_W'(5'd16 >> stage_q);
        mask     = ~({WIDTH{1'b1}} >> shamt);
        take     = ((det_q & mask) == '0);
        det_step = take ? (det_q << shamt) : det_q;
        acc_step = take ? (acc_q + CNT_W'(shamt)) : acc_q;
`ifdef NORM_CTZ_EN
        if (take)
            sh_step = rev_q ? (sh_q >> shamt) : (sh_q << shamt);
        else
            sh_step = sh_q;
`else
        sh_step  = take ? (sh_q << shamt) : sh_q;
`endif
    end

    // Operand conditioning at load: invert for CLO, bit-reverse for CTZ
    always_comb begin
        det_load = (bus.mode == 2'b01) ? ~bus.data_in : bus.data_in;
`ifdef NORM_CTZ_EN
        data_rev = '0;
        for (int i = 0; i < int'(WIDTH); i++)
            data_rev[i] = bus.data_in[int'(WIDTH) - 1 - i];
        if (bus.mode == 2'b10)
            det_load = data_rev;
`endif
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        det_d   = det_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        norm_d  = norm_q;
        full_d  = full_q;
`ifdef NORM_CTZ_EN
        rev_d   = rev_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    stage_d = '0;
                    det_d   = det_load;
                    sh_d    = bus.data_in;
                    acc_d   = '0;
                    busy_d  = 1'b1;
`ifdef NORM_CTZ_EN
                    rev_d   = (bus.mode == 2'b10);
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                det_d = det_step;
                sh_d  = sh_step;
                acc_d = acc_step;
                if (stage_q == STG_W'(LAST_STG)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // A still-clear MSB after all stages means no set bit anywhere
                    if (!det_step[WIDTH-1]) begin
                        count_d = CNT_W'(WIDTH);
                        norm_d  = '0;
                        full_d  = 1'b1;
                    end else begin
                        count_d = acc_step;
                        norm_d  = sh_step;
                        full_d  = 1'b0;
                    end
                end else begin
                    stage_d = stage_q + STG_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            det_q   <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            norm_q  <= '0;
            full_q  <= 1'b0;
`ifdef NORM_CTZ_EN
            rev_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            det_q   <= det_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            norm_q  <= norm_d;
            full_q  <= full_d;
`ifdef NORM_CTZ_EN
            rev_q   <= rev_d;
`endif
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.norm_out = norm_q;
    assign bus.full_run = full_q;
endmodule
